// File: rtl/uart_rx_word_demux.sv
// uart_rx_word_demux
//   Receive-side word demultiplexer. A header byte 0xA8..0xAA selects the
//   destination (A/B/C). The next LENGTH/8 bytes are assembled LSB first into
//   one word, which is then written to that destination register with a
//   one-cycle valid pulse.
// Ports
//   clk, rst           rising-edge clock, synchronous active-high reset
//   enable             1 = advance, 0 = freeze all state (pulses drop to 0)
//   rx_data, rx_valid  received byte and its one-cycle strobe
//   A/B/C_out          destination word registers
//   A/B/C_valid        one-cycle update pulses
//   sel                destination code of the frame in progress or last decoded
//   err                one-cycle frame error (bad header, timeout, overrun)
module uart_rx_word_demux #(
    parameter int LENGTH  = 32,
    parameter int TIMEOUT = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [LENGTH-1:0] A_out,
    output logic [LENGTH-1:0] B_out,
    output logic [LENGTH-1:0] C_out,
    output logic              A_valid,
    output logic              B_valid,
    output logic              C_valid,
    output logic [1:0]        sel,
    output logic              err
);

    localparam int BYTES = LENGTH / 8;
    localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PAYLOAD = 2'b01,
        COMMIT  = 2'b10
    } state_t;

    state_t            state_r, state_next;
    logic [CW-1:0]     cnt_r;
    logic [TW-1:0]     tcnt_r;
    logic [LENGTH-1:0] shift_r;
    logic [LENGTH-1:0] a_r, b_r, c_r;
    logic              a_valid_r, b_valid_r, c_valid_r;
    logic [1:0]        sel_r;
    logic              err_r;

    logic              hdr_ok_s, hdr_err_s, shift_s, final_s;
    logic              timeout_s, tcnt_inc_s, overrun_s;
    logic [LENGTH-1:0] assembled_s;

    // New bytes enter at the top so the first payload byte ends up in bits 7:0.
    assign assembled_s = {rx_data, shift_r[LENGTH-1:8]};

    // Next-state and per-cycle action decode.
    always_comb begin
        state_next = state_r;
        hdr_ok_s   = 1'b0;
        hdr_err_s  = 1'b0;
        shift_s    = 1'b0;
        final_s    = 1'b0;
        timeout_s  = 1'b0;
        tcnt_inc_s = 1'b0;
        overrun_s  = 1'b0;
        if (enable) begin
            case (state_r)
                IDLE: begin
                    if (rx_valid) begin
                        if ((rx_data[7:2] == 6'h2A) && (rx_data[1:0] != 2'b11)) begin
                            hdr_ok_s   = 1'b1;
                            state_next = PAYLOAD;
                        end else begin
                            hdr_err_s = 1'b1;
                        end
                    end else begin
                        state_next = IDLE;
                    end
                end
                PAYLOAD: begin
                    if (rx_valid) begin
                        shift_s = 1'b1;
                        if (cnt_r == CW'(BYTES - 1)) begin
                            final_s    = 1'b1;
                            state_next = COMMIT;
                        end else begin
                            state_next = PAYLOAD;
                        end
                    end else if ((TIMEOUT != 0) && (tcnt_r == TW'(TIMEOUT - 1))) begin
                        // This idle cycle is the TIMEOUT-th in a row.
                        timeout_s  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        tcnt_inc_s = 1'b1;
                    end
                end
                COMMIT: begin
                    state_next = IDLE;
                    overrun_s  = rx_valid;
                end
                default: state_next = IDLE;
            endcase
        end else begin
            state_next = state_r;
        end
    end

    // FSM state, byte assembly and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            tcnt_r  <= '0;
            shift_r <= '0;
        end else if (enable) begin
            state_r <= state_next;
            if (hdr_ok_s) begin
                cnt_r   <= '0;
                tcnt_r  <= '0;
                shift_r <= '0;
            end else if (shift_s) begin
                cnt_r   <= cnt_r + CW'(1);
                tcnt_r  <= '0;
                shift_r <= assembled_s;
            end else if (tcnt_inc_s && (tcnt_r != {TW{1'b1}})) begin
                tcnt_r <= tcnt_r + TW'(1);
            end else begin
                tcnt_r <= tcnt_r;
            end
        end else begin
            state_r <= state_r;
        end
    end

    // Destination registers, pulses, sel and registered error.
    // The word is written on the edge that samples the final byte, so the
    // valid pulse and the new value are both visible during the COMMIT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r       <= '0;
            b_r       <= '0;
            c_r       <= '0;
            a_valid_r <= 1'b0;
            b_valid_r <= 1'b0;
            c_valid_r <= 1'b0;
            sel_r     <= 2'b11;
            err_r     <= 1'b0;
        end else if (enable) begin
            a_valid_r <= 1'b0;
            b_valid_r <= 1'b0;
            c_valid_r <= 1'b0;
            err_r     <= hdr_err_s | timeout_s;
            if (hdr_ok_s) begin
                sel_r <= rx_data[1:0];
            end else begin
                sel_r <= sel_r;
            end
            if (final_s) begin
                case (sel_r)
                    2'b00: begin a_r <= assembled_s; a_valid_r <= 1'b1; end
                    2'b01: begin b_r <= assembled_s; b_valid_r <= 1'b1; end
                    2'b10: begin c_r <= assembled_s; c_valid_r <= 1'b1; end
                    default: ;
                endcase
            end else begin
                a_r <= a_r;
            end
        end else begin
            a_valid_r <= 1'b0;
            b_valid_r <= 1'b0;
            c_valid_r <= 1'b0;
            err_r     <= 1'b0;
        end
    end

    assign A_out   = a_r;
    assign B_out   = b_r;
    assign C_out   = c_r;
    assign A_valid = a_valid_r;
    assign B_valid = b_valid_r;
    assign C_valid = c_valid_r;
    assign sel     = sel_r;
    // An overrun byte arrives during the COMMIT cycle itself; it has to be
    // flagged alongside the valid pulse, hence the direct combinational term.
    assign err     = err_r | overrun_s;

endmodule

// File: tb/tb_uart_rx_word_demux.sv
// Scoreboard bench for uart_rx_word_demux: stimulus pushes the expected
// output event, a negedge monitor pops and compares on every valid/err.
module tb_uart_rx_word_demux;

    logic        clk = 1'b0;
    logic        rst, enable, rx_valid;
    logic [7:0]  rx_data;
    logic [31:0] A_out, B_out, C_out;
    logic        A_valid, B_valid, C_valid, err;
    logic [1:0]  sel;

    typedef struct {
        logic [2:0]  kind;  // 0=A 1=B 2=C 3=no valid
        logic        e;
        logic [31:0] a, b, c;
        logic [1:0]  s;
    } item_t;

    item_t       q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] ma, mb, mc;
    logic [1:0]  msel;

    uart_rx_word_demux #(.LENGTH(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .rx_data(rx_data), .rx_valid(rx_valid),
        .A_out(A_out), .B_out(B_out), .C_out(C_out),
        .A_valid(A_valid), .B_valid(B_valid), .C_valid(C_valid),
        .sel(sel), .err(err)
    );

    always #5 clk = ~clk;

    // Monitor: every output event must match the oldest expected event.
    always @(negedge clk) begin
        if (!rst && (A_valid || B_valid || C_valid || err)) begin
            logic [2:0] got;
            item_t      x;
            case ({A_valid, B_valid, C_valid})
                3'b100:  got = 3'd0;
                3'b010:  got = 3'd1;
                3'b001:  got = 3'd2;
                3'b000:  got = 3'd3;
                default: got = 3'd4;
            endcase
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: kind=%0d err=%0b required no event", got, err);
            end else begin
                x = q.pop_front();
                if (got != x.kind || err != x.e || A_out != x.a || B_out != x.b ||
                    C_out != x.c || sel != x.s) begin
                    errors++;
                    $display("FAIL event: got kind=%0d err=%0b A=%h B=%h C=%h sel=%b required kind=%0d err=%0b A=%h B=%h C=%h sel=%b",
                             got, err, A_out, B_out, C_out, sel, x.kind, x.e, x.a, x.b, x.c, x.s);
                end
            end
        end
    end

    task automatic push(input logic [2:0] kind, input logic e);
        item_t x;
        x.kind = kind; x.e = e; x.a = ma; x.b = mb; x.c = mc; x.s = msel;
        q.push_back(x);
    endtask

    task automatic exp_commit(input logic [1:0] d, input logic [31:0] w, input logic e);
        msel = d;
        case (d)
            2'b00:   ma = w;
            2'b01:   mb = w;
            default: mc = w;
        endcase
        push({1'b0, d}, e);
    endtask

    // Caller is aligned just after a rising edge; byte is sampled at the next edge.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check_quiet(input string name);
        @(negedge clk);
        checks++;
        if (A_out != ma || B_out != mb || C_out != mc || sel != msel ||
            {A_valid, B_valid, C_valid, err} != 4'b0000) begin
            errors++;
            $display("FAIL %s: got A=%h B=%h C=%h sel=%b pulses=%b required A=%h B=%h C=%h sel=%b pulses=0000",
                     name, A_out, B_out, C_out, sel, {A_valid, B_valid, C_valid, err}, ma, mb, mc, msel);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        ma = 32'h0; mb = 32'h0; mc = 32'h0; msel = 2'b11;
        idle(3);
        rst = 1'b0;
        check_quiet("reset_state");

        // 1: frame to A
        exp_commit(2'b00, 32'h12345678, 1'b0);
        send(8'hA8); send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        idle(2);

        // 2: header with code 11 rejected, then frame to C
        push(3'd3, 1'b1);
        send(8'hAB); idle(2);
        exp_commit(2'b10, 32'hDEADBEEF, 1'b0);
        send(8'hAA); send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        idle(2);

        // 3: bad prefix rejected, then frame to B
        push(3'd3, 1'b1);
        send(8'h55); idle(2);
        exp_commit(2'b01, 32'h00000001, 1'b0);
        send(8'hA9); send(8'h01); send(8'h00); send(8'h00); send(8'h00);
        idle(2);

        // 4: 15-cycle gap tolerated, 16-cycle gap times out, then a clean frame
        msel = 2'b01;
        push(3'd3, 1'b1);
        send(8'hA9); idle(15); send(8'h11); send(8'h22);
        idle(16); idle(2);
        check_quiet("after_timeout");
        exp_commit(2'b00, 32'h04030201, 1'b0);
        send(8'hA8); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        idle(2);

        // 5: reset mid-frame, leftover payload bytes become bad headers
        send(8'hA8); send(8'h01); send(8'h02);
        rst = 1'b1; idle(1);
        ma = 32'h0; mb = 32'h0; mc = 32'h0; msel = 2'b11;
        rst = 1'b0;
        check_quiet("reset_midframe");
        push(3'd3, 1'b1);
        push(3'd3, 1'b1);
        send(8'h03); send(8'h04); idle(2);

        // 6: frame ignored while disabled, then commit with overrun byte
        enable = 1'b0;
        send(8'hA8); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        idle(3);
        enable = 1'b1;
        check_quiet("disabled_frame");
        exp_commit(2'b00, 32'h44332211, 1'b1);
        send(8'hA8); send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h99);
        idle(3);
        check_quiet("after_overrun");

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_events: got %0d events outstanding required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
